riscv_mc_control: RTL and testbench



---
 rtl/riscv_mc_control.sv | 191 +++++++++++++++++++
 tb/tb_riscv_mc_control.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_control.sv
// Multicycle RV32I-subset control unit: Moore sequencer plus ALU/immediate decode.
// Outputs are combinational from state and the instruction fields.
module riscv_mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [2:0] aluctr,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_aluop;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_DECODE;
        endcase
    end

    always_comb begin
        adrsrc     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        w_aluop    = 2'b00;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: w_illegal = 1'b0;
                    default:                                 w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: adrsrc = 1'b1;
            S_MEMWB: begin
                resultsrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                w_aluop = 2'b10;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                w_aluop = 2'b10;
            end
            S_ALUWB: w_regwrite = 1'b1;
            S_BEQ: begin
                alusrca  = 2'b10;
                w_aluop  = 2'b01;
                w_branch = 1'b1;
            end
            S_JAL: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                w_pcupdate = 1'b1;
            end
            // FETCH and the unreachable codes share the fetch controls
            default: begin
                w_irwrite  = 1'b1;
                alusrcb    = 2'b10;
                resultsrc  = 2'b10;
                w_pcupdate = 1'b1;
            end
        endcase
    end

    always_comb begin
        aluctr = ALU_ADD;
        case (w_aluop)
            2'b01: aluctr = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  aluctr = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluctr = ALU_SLT;
                    3'b110:  aluctr = ALU_OR;
                    3'b111:  aluctr = ALU_AND;
                    default: aluctr = ALU_ADD;
                endcase
            end
            default: aluctr = ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // Write enables are held off while reset is high, before any clock edge
    assign pcwrite  = ~reset & (w_pcupdate | (w_branch & zero));
    assign irwrite  = ~reset & w_irwrite;
    assign regwrite = ~reset & w_regwrite;
    assign memwrite = ~reset & w_memwrite;
    assign illegal  = ~reset & w_illegal;
    assign state    = r_state;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Bench for riscv_mc_control: vector table, hand sequences and a
// randomized instruction stream checked against a per-instruction model.
module tb_riscv_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] aluctr;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    riscv_mc_control dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pcwrite(pcwrite),
        .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .immsrc(immsrc), .aluctr(aluctr),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    wire [20:0] w_dut = {pcwrite, adrsrc, memwrite, irwrite, regwrite,
                         resultsrc, alusrca, alusrcb, immsrc, aluctr,
                         illegal, state};

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: the list of states an instruction visits
    int seq[6];
    int seq_n;

    task automatic build_seq(input logic [6:0] o);
        seq[0] = 0; seq[1] = 1; seq_n = 2;
        case (o)
            LW:  begin seq[2] = 2; seq[3] = 3; seq[4] = 4; seq_n = 5; end
            SW:  begin seq[2] = 2; seq[3] = 5; seq_n = 4; end
            RT:  begin seq[2] = 6; seq[3] = 8; seq_n = 4; end
            IT:  begin seq[2] = 7; seq[3] = 8; seq_n = 4; end
            BEQ: begin seq[2] = 9; seq_n = 3; end
            JAL: begin seq[2] = 10; seq[3] = 8; seq_n = 4; end
            default: seq_n = 2;
        endcase
    endtask

    function automatic logic [2:0] m_alu(int s, logic [6:0] o,
                                         logic [2:0] f3, logic f7);
        if (s == 9) return 3'b110;
        if (s == 6 || s == 7) begin
            if (f3 == 3'b010) return 3'b111;
            if (f3 == 3'b110) return 3'b001;
            if (f3 == 3'b111) return 3'b000;
            if (f3 == 3'b000 && f7 && o == RT) return 3'b110;
        end
        return 3'b010;
    endfunction

    function automatic logic [1:0] m_imm(logic [6:0] o);
        if (o == SW)  return 2'b01;
        if (o == BEQ) return 2'b10;
        if (o == JAL) return 2'b11;
        return 2'b00;
    endfunction

    // {adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb}
    function automatic logic [9:0] m_ctl(int s);
        case (s)
            0:  return 10'b0_0_1_0_10_00_10;
            1:  return 10'b0_0_0_0_00_01_01;
            2:  return 10'b0_0_0_0_00_10_01;
            3:  return 10'b1_0_0_0_00_00_00;
            4:  return 10'b0_0_0_1_01_00_00;
            5:  return 10'b1_1_0_0_00_00_00;
            6:  return 10'b0_0_0_0_00_10_00;
            7:  return 10'b0_0_0_0_00_10_01;
            8:  return 10'b0_0_0_1_00_00_00;
            9:  return 10'b0_0_0_0_00_10_00;
            default: return 10'b0_0_0_0_00_01_10;
        endcase
    endfunction

    function automatic logic [20:0] model(int s, logic [6:0] o, logic [2:0] f3,
                                          logic f7, logic z, logic ill);
        logic pcw;
        logic [3:0] sc;
        pcw = (s == 0 || s == 10) ? 1'b1 : (s == 9) ? z : 1'b0;
        sc  = 4'(s);
        return {pcw, m_ctl(s), m_imm(o), m_alu(s, o, f3, f7),
                ill && s == 1, sc};
    endfunction

    task automatic run_model(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        build_seq(o);
        for (int k = 0; k < seq_n; k++) begin
            #1;
            chk($sformatf("rand op=%b st=%0d", o, seq[k]), 32'(w_dut),
                32'(model(seq[k], o, f3, f7, z, seq_n == 2)));
            step();
        end
        chk("rand return", 32'(state), 32'd0);
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cyc;
        logic [2:0] ex_alu;
        logic       ex_pcw;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n;
        logic [2:0] got_alu;
        logic got_pcw;
        logic [6:0] ops[7];

        tbl[0]  = '{LW,  3'b000, 1'b0, 1'b0, 5, 3'b010, 1'b0};
        tbl[1]  = '{SW,  3'b010, 1'b0, 1'b0, 4, 3'b010, 1'b0};
        tbl[2]  = '{RT,  3'b000, 1'b0, 1'b0, 4, 3'b010, 1'b0};
        tbl[3]  = '{RT,  3'b000, 1'b1, 1'b0, 4, 3'b110, 1'b0};
        tbl[4]  = '{RT,  3'b010, 1'b0, 1'b0, 4, 3'b111, 1'b0};
        tbl[5]  = '{RT,  3'b110, 1'b0, 1'b0, 4, 3'b001, 1'b0};
        tbl[6]  = '{RT,  3'b111, 1'b1, 1'b0, 4, 3'b000, 1'b0};
        tbl[7]  = '{RT,  3'b001, 1'b0, 1'b0, 4, 3'b010, 1'b0};
        tbl[8]  = '{IT,  3'b000, 1'b1, 1'b0, 4, 3'b010, 1'b0};
        tbl[9]  = '{IT,  3'b010, 1'b0, 1'b0, 4, 3'b111, 1'b0};
        tbl[10] = '{BEQ, 3'b000, 1'b0, 1'b1, 3, 3'b110, 1'b1};
        tbl[11] = '{BEQ, 3'b000, 1'b0, 1'b0, 3, 3'b110, 1'b0};
        tbl[12] = '{JAL, 3'b000, 1'b0, 1'b0, 4, 3'b010, 1'b1};
        tbl[13] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 2, 3'b010, 1'b0};

        reset = 1'b1; op = SW; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset state", 32'(state), 32'd0);
        chk("reset enables", 32'({pcwrite, irwrite, regwrite, memwrite, illegal}), 32'd0);
        chk("reset muxes", 32'({adrsrc, alusrca, alusrcb, resultsrc, aluctr}),
            32'({1'b0, 2'b00, 2'b10, 2'b10, 3'b010}));
        chk("reset immsrc", 32'(immsrc), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            op = tbl[i].op; funct3 = tbl[i].f3;
            funct7b5 = tbl[i].f7; zero = tbl[i].z;
            n = 0; got_alu = 3'b0; got_pcw = 1'b0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if (k == 2) begin
                    got_alu = aluctr;
                    got_pcw = pcwrite;
                end
                step();
                n++;
                if (state == 4'd0) break;
            end
            chk($sformatf("tbl%0d cycles", i), 32'(n), 32'(tbl[i].cyc));
            if (tbl[i].cyc > 2) begin
                chk($sformatf("tbl%0d aluctr", i), 32'(got_alu), 32'(tbl[i].ex_alu));
                chk($sformatf("tbl%0d pcwrite", i), 32'(got_pcw), 32'(tbl[i].ex_pcw));
            end
        end

        op = 7'b1111111;
        #1 chk("illegal in fetch", 32'(illegal), 32'd0);
        step();
        chk("illegal decode", 32'({state, illegal}), 32'({4'd1, 1'b1}));
        step();
        chk("illegal after", 32'({state, illegal}), 32'({4'd0, 1'b0}));

        op = SW;
        step(); step(); step();
        chk("sw in memwrite", 32'({state, memwrite}), 32'({4'd5, 1'b1}));
        #2 reset = 1'b1;
        #1;
        chk("async reset state", 32'(state), 32'd0);
        chk("async reset memwrite", 32'(memwrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("first edge after reset", 32'(state), 32'd1);
        @(negedge clk);
        for (int k = 0; k < 10 && state != 4'd0; k++) step();
        chk("resync", 32'(state), 32'd0);

        ops = '{LW, SW, RT, IT, BEQ, JAL, 7'b0};
        for (int i = 0; i < 150; i++) begin
            logic [6:0] o;
            o = ops[$urandom_range(0, 6)];
            if (o == 7'b0) o = 7'($urandom);
            run_model(o, 3'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
